// File: rtl/solar_pkg.sv
// Shared types and servo/ADC constants for the single-axis sun tracker.
package solar_pkg;

  localparam int ADC_W = 12;
  localparam int PW_W  = 18;

  localparam int unsigned PW_MIN    = 125000;
  localparam int unsigned PW_CENTER = 187500;
  localparam int unsigned PW_MAX    = 250000;

  typedef enum logic [2:0] {
    IDLE,
    REQ_E,
    WAIT_E,
    REQ_W,
    WAIT_W,
    DECIDE,
    SETTLE
  } state_t;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/solar_tracker_ctrl_cycle_timer.sv
// Loadable down-counter; done is high while the count sits at zero.
module cycle_timer #(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done = (count_q == '0);

endmodule

// File: rtl/solar_tracker_ctrl.sv
// Sun-tracking sequencer: samples east/west light sensors, nudges the servo
// pulse width toward the brighter side, then waits for the panel to settle.
module solar_tracker_ctrl
  import solar_pkg::*;
#(
  parameter int unsigned PW_STEP       = 1250,
  parameter int unsigned DEADBAND      = 40,
  parameter int unsigned SETTLE_CYCLES = 12500000,
  parameter int unsigned ADC_TIMEOUT   = 125000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic             adc_req,
  output logic             adc_ch,
  input  logic             adc_ack,
  input  logic [ADC_W-1:0] adc_data,
  output logic [PW_W-1:0]  pulse_width,
  output logic             busy,
  output logic             err_timeout
);

  localparam int unsigned TMR_MAX = max_u(SETTLE_CYCLES, ADC_TIMEOUT);
  localparam int          TMR_W   = $clog2(TMR_MAX + 1);

  localparam logic [TMR_W-1:0] TMO_LOAD    = TMR_W'(ADC_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'(SETTLE_CYCLES - 1);

  // Saturation runs one bit wider than the command so the step cannot wrap.
  localparam logic [PW_W:0] PW_MIN_X = (PW_W + 1)'(PW_MIN);
  localparam logic [PW_W:0] PW_MAX_X = (PW_W + 1)'(PW_MAX);
  localparam logic [PW_W:0] STEP_X   = (PW_W + 1)'(PW_STEP);

  localparam logic signed [ADC_W:0] DB_POS = (ADC_W + 1)'(DEADBAND);
  localparam logic signed [ADC_W:0] DB_NEG = -DB_POS;

  state_t state_q;
  state_t state_d;

  logic [ADC_W-1:0] east_s_q;
  logic [ADC_W-1:0] east_s_d;
  logic [ADC_W-1:0] west_s_q;
  logic [ADC_W-1:0] west_s_d;
  logic [PW_W-1:0]  pw_q;
  logic [PW_W-1:0]  pw_d;
  logic             err_q;
  logic             err_d;

  logic             tmr_load;
  logic [TMR_W-1:0] tmr_val;
  logic             tmr_done;

  logic signed [ADC_W:0] diff;
  logic [PW_W:0]         pw_x;
  logic [PW_W:0]         pw_up;
  logic [PW_W:0]         pw_up_sat;
  logic [PW_W:0]         pw_dn_sat;

  cycle_timer #(
    .W(TMR_W)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  assign diff      = $signed({1'b0, east_s_q}) - $signed({1'b0, west_s_q});
  assign pw_x      = {1'b0, pw_q};
  assign pw_up     = pw_x + STEP_X;
  assign pw_up_sat = (pw_up > PW_MAX_X) ? PW_MAX_X : pw_up;
  assign pw_dn_sat = (pw_x < (PW_MIN_X + STEP_X)) ? PW_MIN_X : (pw_x - STEP_X);

  always_comb begin
    state_d  = state_q;
    east_s_d = east_s_q;
    west_s_d = west_s_q;
    pw_d     = pw_q;
    err_d    = err_q;
    tmr_load = 1'b0;
    tmr_val  = '0;

    case (state_q)
      IDLE: begin
        if (en) begin
          state_d = REQ_E;
        end
      end

      REQ_E: begin
        tmr_load = 1'b1;
        tmr_val  = TMO_LOAD;
        state_d  = WAIT_E;
      end

      // An ack arriving on the final timeout cycle still counts.
      WAIT_E: begin
        if (adc_ack) begin
          east_s_d = adc_data;
          state_d  = REQ_W;
        end else if (tmr_done) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end

      REQ_W: begin
        tmr_load = 1'b1;
        tmr_val  = TMO_LOAD;
        state_d  = WAIT_W;
      end

      WAIT_W: begin
        if (adc_ack) begin
          west_s_d = adc_data;
          state_d  = DECIDE;
        end else if (tmr_done) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end

      // East brighter means the sun is east: move toward the low pulse width.
      DECIDE: begin
        if (diff > DB_POS) begin
          pw_d = PW_W'(pw_dn_sat);
        end else if (diff < DB_NEG) begin
          pw_d = PW_W'(pw_up_sat);
        end
        err_d    = 1'b0;
        tmr_load = 1'b1;
        tmr_val  = SETTLE_LOAD;
        state_d  = SETTLE;
      end

      SETTLE: begin
        if (tmr_done) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      east_s_q <= '0;
      west_s_q <= '0;
      pw_q     <= PW_W'(PW_CENTER);
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      east_s_q <= east_s_d;
      west_s_q <= west_s_d;
      pw_q     <= pw_d;
      err_q    <= err_d;
    end
  end

  assign adc_req     = (state_q == REQ_E) || (state_q == REQ_W);
  assign adc_ch      = (state_q == REQ_W) || (state_q == WAIT_W);
  assign busy        = (state_q != IDLE);
  assign pulse_width = pw_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_solar_tracker_ctrl.sv
// Directed bench for solar_tracker_ctrl with short settle/timeout intervals.
module tb_solar_tracker_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        adc_ack = 1'b0;
  logic [11:0] adc_data = '0;
  logic        adc_req;
  logic        adc_ch;
  logic [17:0] pulse_width;
  logic        busy;
  logic        err_timeout;

  int checks = 0;
  int errors = 0;
  int model_pw = 187500;
  int exp_q[$];

  solar_tracker_ctrl #(
    .SETTLE_CYCLES (16),
    .ADC_TIMEOUT   (32)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .adc_req     (adc_req),
    .adc_ch      (adc_ch),
    .adc_ack     (adc_ack),
    .adc_data    (adc_data),
    .pulse_width (pulse_width),
    .busy        (busy),
    .err_timeout (err_timeout)
  );

  always #4 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  function automatic int next_pw(input int pw, input int e, input int w);
    int d;
    d = e - w;
    if (d > 40) begin
      return (pw - 1250 < 125000) ? 125000 : pw - 1250;
    end else if (d < -40) begin
      return (pw + 1250 > 250000) ? 250000 : pw + 1250;
    end
    return pw;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_req(input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (adc_req === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk(tag, {31'd0, ok}, 32'd1);
  endtask

  // Called during a REQ cycle; answers after 0..3 extra WAIT cycles.
  task automatic do_ack(input logic [11:0] v, input logic ch, input bit drop_en);
    int d;
    @(posedge clk);
    #1;
    chk("req_one_cycle", {31'd0, adc_req}, 32'd0);
    if (drop_en) en = 1'b0;
    d = $urandom_range(0, 3);
    if (d > 0) begin
      repeat (d) @(posedge clk);
      #1;
    end
    chk("ch_held", {31'd0, adc_ch}, {31'd0, ch});
    adc_ack  = 1'b1;
    adc_data = v;
    @(posedge clk);
    #1;
    adc_ack = 1'b0;
  endtask

  task automatic run_cycle(input int e, input int w, input bit drop_en);
    int old_pw;
    int exp_pw;
    old_pw = model_pw;
    wait_req("req_east");
    chk("ch_east", {31'd0, adc_ch}, 32'd0);
    do_ack(12'(e), 1'b0, drop_en);
    wait_req("req_west");
    chk("ch_west", {31'd0, adc_ch}, 32'd1);
    model_pw = next_pw(model_pw, e, w);
    exp_q.push_back(model_pw);
    do_ack(12'(w), 1'b1, 1'b0);
    @(negedge clk);
    chk("pw_in_decide", 32'(pulse_width), 32'(old_pw));
    @(negedge clk);
    exp_pw = exp_q.pop_front();
    chk("pw_after_decide", 32'(pulse_width), 32'(exp_pw));
    chk("err_cleared", {31'd0, err_timeout}, 32'd0);
    chk("busy_settle", {31'd0, busy}, 32'd1);
    $display("cycle east=%0d west=%0d pulse_width=%0d expected=%0d", e, w, pulse_width, exp_pw);
  endtask

  task automatic count_reqs(input int n, output int cnt);
    cnt = 0;
    repeat (n) begin
      @(negedge clk);
      if (adc_req === 1'b1) cnt++;
    end
  endtask

  initial begin
    int cnt;
    int exp_pw;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_pw", 32'(pulse_width), 32'd187500);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_req", {31'd0, adc_req}, 32'd0);
    chk("rst_ch", {31'd0, adc_ch}, 32'd0);
    chk("rst_err", {31'd0, err_timeout}, 32'd0);
    rst = 1'b0;
    count_reqs(5, cnt);
    chk("idle_no_req", 32'(cnt), 32'd0);

    // East bright, then cycle period
    en = 1'b1;
    run_cycle(2000, 1000, 1'b0);
    cnt = 0;
    while (adc_req !== 1'b1 && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    chk("decide_to_req", 32'(cnt), 32'd17);

    // Deadband edge
    run_cycle(1000, 1040, 1'b0);
    run_cycle(1000, 1041, 1'b0);
    run_cycle(2000, 1000, 1'b0);

    // Asynchronous reset mid-SETTLE
    #2;
    rst = 1'b1;
    #1;
    chk("arst_pw", 32'(pulse_width), 32'd187500);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_req", {31'd0, adc_req}, 32'd0);
    model_pw = 187500;
    exp_q.delete();
    en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    count_reqs(40, cnt);
    chk("post_rst_no_req", 32'(cnt), 32'd0);

    // Saturation at both ends
    en = 1'b1;
    for (int i = 0; i < 51; i++) run_cycle(100, 3000, 1'b0);
    chk("sat_max", 32'(pulse_width), 32'd250000);
    for (int i = 0; i < 101; i++) run_cycle(3000, 100, 1'b0);
    chk("sat_min", 32'(pulse_width), 32'd125000);

    // Timeout in WAIT_W
    wait_req("to_req_east");
    do_ack(12'd500, 1'b0, 1'b0);
    wait_req("to_req_west");
    exp_q.push_back(model_pw);
    @(posedge clk);
    repeat (31) @(posedge clk);
    #1;
    chk("to_err_before", {31'd0, err_timeout}, 32'd0);
    chk("to_busy_before", {31'd0, busy}, 32'd1);
    @(posedge clk);
    #1;
    chk("to_err", {31'd0, err_timeout}, 32'd1);
    chk("to_idle", {31'd0, busy}, 32'd0);
    exp_pw = exp_q.pop_front();
    chk("to_pw", 32'(pulse_width), 32'(exp_pw));
    $display("timeout err_timeout=%0d pulse_width=%0d expected=%0d", err_timeout, pulse_width, exp_pw);
    wait_req("to_next_req");
    chk("err_sticky", {31'd0, err_timeout}, 32'd1);
    run_cycle(100, 3000, 1'b0);

    // Spurious ack in SETTLE, en dropped during WAIT_E
    @(posedge clk);
    #1;
    adc_ack  = 1'b1;
    adc_data = 12'd4095;
    @(posedge clk);
    #1;
    adc_ack = 1'b0;
    chk("spur_pw", 32'(pulse_width), 32'(model_pw));
    run_cycle(100, 3000, 1'b1);
    count_reqs(40, cnt);
    chk("stop_no_req", 32'(cnt), 32'd0);
    chk("stop_idle", {31'd0, busy}, 32'd0);
    chk("stop_pw", 32'(pulse_width), 32'(model_pw));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
